// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: IM request/response, EX redirect and ID handoff signals
// of the fetch stage. The master modport is the fetch stage itself; the slave
// modport is the surrounding environment (instruction memory, EX, ID).
interface instr_fetch_queue_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  modport master (
    output im_req, im_addr, id_valid, id_pc, id_instr,
    input  im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, id_stall
  );

  modport slave (
    input  im_req, im_addr, id_valid, id_pc, id_instr,
    output im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, id_stall
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage feeding ID. Issues in-order IM reads at
// sequential PCs, buffers returned words with their PCs in a DEPTH-entry FIFO
// and presents the head combinationally. EX redirects flush the FIFO and mark
// every in-flight response as stale.
// Optional feature macro: FETCH_BUBBLE_CNT_EN adds the bubble_cnt output, a
// saturating count of cycles in which ID was ready but no instruction was valid.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_queue_if.master bus
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]         bubble_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;   // PC belonging to the next response that will be kept
  logic [PW-1:0] wptr_q, rptr_q, count;
  logic [OW-1:0] outst_q, drop_q, outst_dec;
  logic          run_q;      // holds im_req low until the first edge after reset
  logic [SW-1:0] occ;
  logic          issue, grant, push, pop, full, head_vld;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  // Occupancy counts both buffered words and words still in flight, so a
  // granted request always has a FIFO slot waiting for its response.
  assign count     = wptr_q - rptr_q;
  assign full      = (count == PW'(DEPTH));
  assign head_vld  = (count != '0);
  assign occ       = SW'(outst_q) + SW'(count);
  assign issue     = run_q && !bus.redirect && (occ < SW'(DEPTH)) &&
                     (outst_q < OW'(MAX_OUTST));
  assign grant     = issue && bus.im_gnt;
  assign outst_dec = bus.im_rvalid ? outst_q - OW'(1) : outst_q;
  assign push      = bus.im_rvalid && !bus.redirect && (drop_q == '0);
  assign pop       = head_vld && !bus.id_stall;

  assign bus.im_req   = issue;
  assign bus.im_addr  = pc_q;
  assign bus.id_valid = head_vld;
  assign bus.id_pc    = head_vld ? pc_mem[rptr_q[AW-1:0]] : '0;
  assign bus.id_instr = head_vld ? instr_mem[rptr_q[AW-1:0]] : NOP;

  // Fetch PC, FIFO pointers and in-flight/drop bookkeeping; redirect overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      wptr_q   <= '0;
      rptr_q   <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (bus.redirect) begin
        pc_q     <= bus.redirect_pc & 32'hFFFF_FFFC;
        rsp_pc_q <= bus.redirect_pc & 32'hFFFF_FFFC;
        rptr_q   <= wptr_q;
        outst_q  <= outst_dec;
        drop_q   <= outst_dec;
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        outst_q <= grant ? outst_dec + OW'(1) : outst_dec;
        if (bus.im_rvalid && (drop_q != '0)) drop_q <= drop_q - OW'(1);
        if (push) begin
          wptr_q   <= wptr_q + PW'(1);
          rsp_pc_q <= rsp_pc_q + 32'd4;
        end
        if (pop) rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  // FIFO storage: instruction word and its PC, written on every kept response.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q[AW-1:0]] <= bus.im_rdata;
      pc_mem[wptr_q[AW-1:0]]    <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  // The issue throttle keeps a push from ever landing on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) begin
      assert (!full) else $error("instr_fetch_queue: push into full FIFO");
    end
  end
`endif

`ifdef FETCH_BUBBLE_CNT_EN
  // Saturating count of cycles where ID could accept but nothing was valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!head_vld && !bus.id_stall && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue with an in-order
// instruction-memory model of programmable latency and a queue-based reference
// of the fetch stage (issued-address list with stale marks, PC queue for ID).
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct { logic [31:0] pc; bit stale; } iss_t;
  typedef struct { logic [31:0] addr; int rdy; } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  instr_fetch_queue_if bus();
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  instr_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH),
    .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef FETCH_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int im_lat = 1;
  int n;
  iss_t        iss[$];    // issued requests still awaiting a response
  logic [31:0] mq[$];     // PCs buffered for ID, head first
  pend_t       pend[$];   // memory-side pending reads
  logic [31:0] m_pc;
  bit          m_run;
  bit          e_req;
  bit          s_req;
  logic [31:0] s_addr;
  logic [31:0] m_bub;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hA500_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_pc, e_instr;
    e_req   = m_run && !bus.redirect && ((iss.size() + mq.size()) < DEPTH) &&
              (iss.size() < MAX_OUTST);
    e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
    e_instr = (mq.size() != 0) ? mem_word(mq[0]) : NOP;
    chk("im_req",   32'(bus.im_req), 32'(e_req));
    chk("im_addr",  bus.im_addr, m_pc);
    chk("id_valid", 32'(bus.id_valid), 32'(mq.size() != 0));
    chk("id_pc",    bus.id_pc, e_pc);
    chk("id_instr", bus.id_instr, e_instr);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, m_bub);
`endif
  endtask

  task automatic model_step();
    iss_t e;
    bit pop_now;
    pop_now = (mq.size() != 0) && !bus.id_stall;
    if ((mq.size() == 0) && !bus.id_stall && (m_bub != 32'hFFFF_FFFF)) m_bub = m_bub + 32'd1;
    if (bus.redirect) begin
      if (bus.im_rvalid && (iss.size() != 0)) void'(iss.pop_front());
      for (int i = 0; i < iss.size(); i++) iss[i].stale = 1'b1;
      mq.delete();
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop_now) void'(mq.pop_front());
      if (bus.im_rvalid && (iss.size() != 0)) begin
        e = iss.pop_front();
        if (!e.stale) mq.push_back(e.pc);
      end
      if (e_req && bus.im_gnt) begin
        iss.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1'b1;
  endtask

  task automatic set_im();
    if ((pend.size() != 0) && (pend[0].rdy <= cyc)) begin
      bus.im_rvalid = 1'b1;
      bus.im_rdata  = mem_word(pend[0].addr);
    end else begin
      bus.im_rvalid = 1'b0;
      bus.im_rdata  = 32'h0BAD_0BAD;
    end
  endtask

  task automatic tick();
    set_im();
    @(negedge clk);
    check_outputs();
    s_req  = bus.im_req;
    s_addr = bus.im_addr;
    @(posedge clk);
    model_step();
    if (bus.im_rvalid && (pend.size() != 0)) void'(pend.pop_front());
    if (s_req && bus.im_gnt) pend.push_back('{addr: s_addr, rdy: cyc + im_lat});
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.im_rvalid = 1'b0;
    pend.delete();
    iss.delete();
    mq.delete();
    m_pc  = 32'h0;
    m_run = 1'b0;
    m_bub = 32'h0;
    #1;
    chk("rst_im_req",   32'(bus.im_req), 32'h0);
    chk("rst_im_addr",  bus.im_addr, 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_id_pc",    bus.id_pc, 32'h0);
    chk("rst_id_instr", bus.id_instr, 32'h0000_0013);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    bus.id_stall = 1'b0;
    bus.redirect = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.im_gnt      = 1'b1;
    bus.im_rvalid   = 1'b0;
    bus.im_rdata    = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_stall    = 1'b0;
    #2;
    apply_reset();

    // Streaming from reset with a 1-cycle memory.
    tick();
    chk("first_req",  32'(bus.im_req), 32'h1);
    chk("first_addr", bus.im_addr, 32'h0);
    tick();
    chk("second_addr", bus.im_addr, 32'h4);
    chk("fill_invalid", 32'(bus.id_valid), 32'h0);
    tick();
    chk("first_valid", 32'(bus.id_valid), 32'h1);
    chk("first_pc",    bus.id_pc, 32'h0);
    chk("first_instr", bus.id_instr, 32'hA500_0003);
    repeat (10) tick();
    chk("stream_pc", bus.id_pc, 32'h0000_0028);

    // Back-pressure: fill, hold, then drain in order.
    bus.id_stall = 1'b1;
    repeat (10) tick();
    chk("stall_req",   32'(bus.im_req), 32'h0);
    chk("stall_pc",    bus.id_pc, 32'h0000_0028);
    chk("stall_instr", bus.id_instr, 32'hA500_002B);
    bus.id_stall = 1'b0;
    repeat (4) tick();
    chk("drain_pc", bus.id_pc, 32'h0000_0038);

    // Redirect with two requests in flight on a 3-cycle memory.
    im_lat = 3;
    n = 0;
    while ((iss.size() != 2) && (n < 20)) begin tick(); n++; end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    tick();
    bus.redirect = 1'b0;
    chk("redir_addr",  bus.im_addr, 32'h0000_0100);
    chk("redir_flush", 32'(bus.id_valid), 32'h0);
    n = 0;
    while (!bus.id_valid && (n < 30)) begin tick(); n++; end
    chk("redir_first_pc",    bus.id_pc, 32'h0000_0100);
    chk("redir_first_instr", bus.id_instr, 32'hA500_0103);

    // Redirect coinciding with a response while ID is stalled.
    im_lat = 1;
    bus.id_stall = 1'b1;
    n = 0;
    while (!((pend.size() != 0) && (pend[0].rdy <= cyc)) && (n < 10)) begin tick(); n++; end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    chk("rv_redir_empty", 32'(bus.id_valid), 32'h0);
    chk("rv_redir_addr",  bus.im_addr, 32'h0000_0100);
    repeat (3) tick();
    bus.id_stall = 1'b0;
    repeat (8) tick();

    // Address wrap at the top of the 32-bit space, then grant gaps.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    chk("wrap_addr0", bus.im_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", bus.im_addr, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      bus.im_gnt = (i % 2) == 1;
      tick();
    end
    bus.im_gnt = 1'b1;
    repeat (4) tick();

    // Back-to-back redirects: the later target wins.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick();
    bus.redirect_pc = 32'h0000_0300;
    tick();
    bus.redirect = 1'b0;
    chk("b2b_addr", bus.im_addr, 32'h0000_0300);
    n = 0;
    while (!bus.id_valid && (n < 30)) begin tick(); n++; end
    chk("b2b_pc", bus.id_pc, 32'h0000_0300);

    // Asynchronous reset in the middle of a cycle with a full FIFO.
    bus.id_stall = 1'b1;
    repeat (8) tick();
    chk("pre_reset_valid", 32'(bus.id_valid), 32'h1);
    #2;
    apply_reset();
    tick();
    chk("rerun_req",  32'(bus.im_req), 32'h1);
    chk("rerun_addr", bus.im_addr, 32'h0);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
